// File: rtl/et_lock_pkg.sv
// Shared types and constants for the locked ETA-II adder.
// Key FSM states, default key polarity, segment count helper.
package et_lock_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    SHIFTING,
    ARMED
  } key_state_t;

  localparam logic [7:0] KPOL_DEF = 8'hA5;

  function automatic int nseg(input int w, input int seg);
    return w / seg;
  endfunction

endpackage

// File: rtl/et2_segment.sv
// One ETA-II segment: local add with predicted carry-in.
// Sum is inverted by the key mask bit km.
module et2_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  input  logic           km,
  output logic [SEG-1:0] sum,
  output logic           g,
  output logic           co
);

  logic [SEG:0] gen_sum;
  logic [SEG:0] full_sum;

  assign gen_sum  = {1'b0, a} + {1'b0, b};
  assign full_sum = gen_sum + {{SEG{1'b0}}, cin};

  assign g   = gen_sum[SEG];
  assign co  = full_sum[SEG];
  assign sum = full_sum[SEG-1:0] ^ {SEG{km}};

endmodule

// File: rtl/et2_adder_locked_pipe.sv
// Pipelined, key-locked ETA-II adder with serial key load.
// Two register stages behind a valid/ready handshake.
module et2_adder_locked_pipe
  import et_lock_pkg::*;
#(
  parameter int W   = 16,
  parameter int SEG = 4,
  parameter logic [2*(W/SEG)-1:0] KPOL =
    (2*(W/SEG))'(KPOL_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] add1_i,
  input  logic [W-1:0] add2_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   result_o,
  input  logic         key_in,
  input  logic         key_shift,
  input  logic         key_commit,
  output logic         key_armed,
  output logic         key_err
);

  localparam int NSEG  = nseg(W, SEG);
  localparam int KEY_W = 2 * NSEG;
  localparam int CW    = $clog2(KEY_W + 1);
  localparam logic [CW-1:0] FULL = CW'(KEY_W);

  if (W % SEG != 0) begin : g_bad_w
    $error("W must be a multiple of SEG");
  end

  key_state_t       state;
  logic [KEY_W-1:0] shadow;
  logic [KEY_W-1:0] shadow_nx;
  logic [KEY_W-1:0] act_key;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;

  logic en;
  logic accept;

  logic [NSEG-1:0] kc;
  logic [NSEG-1:0] km;
  logic [NSEG-1:0] cin;
  logic [NSEG-1:0] g;
  logic [NSEG-1:0] co;
  logic [W-1:0]    sum_c;

  logic         s1_valid;
  logic [W-1:0] s1_sum;
  logic         s1_co;

  logic unused_carries;

  assign key_armed = (state == ARMED);
  assign en        = !out_valid || out_ready;
  assign in_ready  = key_armed && en;
  assign accept    = in_valid && in_ready;

  // Shift is applied before any same-cycle commit looks at the count.
  always_comb begin
    shadow_nx = shadow;
    cnt_nx    = cnt;
    if (key_shift) begin
      shadow_nx = {key_in, shadow[KEY_W-1:1]};
      if (cnt != FULL) cnt_nx = cnt + 1'b1;
    end
  end

  // Key load FSM: shadow shifting, commit check, error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      shadow  <= '0;
      act_key <= '0;
      cnt     <= '0;
      key_err <= 1'b0;
    end else begin
      key_err <= 1'b0;
      if (key_shift) begin
        state  <= SHIFTING;
        shadow <= shadow_nx;
        cnt    <= cnt_nx;
      end
      if (key_commit) begin
        cnt <= '0;
        if (cnt_nx == FULL) begin
          act_key <= shadow_nx;
          state   <= ARMED;
        end else begin
          key_err <= 1'b1;
          state   <= EMPTY;
        end
      end
    end
  end

  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    assign kc[s] = act_key[2*s]   ^ KPOL[2*s];
    assign km[s] = act_key[2*s+1] ^ KPOL[2*s+1];

    if (s == 0) begin : g_c0
      assign cin[s] = kc[s];
    end else begin : g_cn
      assign cin[s] = g[s-1] ^ kc[s];
    end

    et2_segment #(.SEG(SEG)) u_seg (
      .a   (add1_i[s*SEG +: SEG]),
      .b   (add2_i[s*SEG +: SEG]),
      .cin (cin[s]),
      .km  (km[s]),
      .sum (sum_c[s*SEG +: SEG]),
      .g   (g[s]),
      .co  (co[s])
    );
  end

  assign unused_carries = ^{g[NSEG-1], co};

  // Stage 1: capture gated segment sums and top carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_co    <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum <= sum_c;
        s1_co  <= co[NSEG-1];
      end
    end
  end

  // Stage 2: output register, frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result_o  <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) result_o <= {s1_co, s1_sum};
    end
  end

endmodule

// File: tb/tb_et2_adder_locked_pipe.sv
// Directed bench for the locked ETA-II pipeline.
// Inputs driven and outputs sampled on the falling edge.
module tb_et2_adder_locked_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] add1_i;
  logic [15:0] add2_i;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] result_o;
  logic        key_in;
  logic        key_shift;
  logic        key_commit;
  logic        key_armed;
  logic        key_err;

  int n_err = 0;
  int n_chk = 0;

  et2_adder_locked_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .add1_i     (add1_i),
    .add2_i     (add2_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_o   (result_o),
    .key_in     (key_in),
    .key_shift  (key_shift),
    .key_commit (key_commit),
    .key_armed  (key_armed),
    .key_err    (key_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [7:0] k, input int nb);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      key_shift = 1'b1;
      key_in    = k[i];
    end
    @(negedge clk);
    key_shift  = 1'b0;
    key_in     = 1'b0;
    key_commit = 1'b1;
    @(negedge clk);
    key_commit = 1'b0;
  endtask

  task automatic run_one(input string tag,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input logic [16:0] exp);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    add1_i    = a;
    add2_i    = b;
    #1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(result_o), 32'(exp));
  endtask

  task automatic stream(input int stall_lo,
                        input int stall_hi,
                        input int n);
    logic [16:0] q[$];
    logic        hold_v;
    logic [16:0] hold_r;
    int          sent;
    int          got;
    hold_v = 1'b0;
    hold_r = '0;
    sent   = 0;
    got    = 0;
    for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
      @(negedge clk);
      if (hold_v) begin
        chk("hold_vld", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(result_o), 32'(hold_r));
      end
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      in_valid  = (sent < n);
      add1_i    = 16'(16'h1111 * (sent + 1));
      add2_i    = 16'h0101;
      #1;
      if (in_valid && in_ready) begin
        q.push_back({1'b0, add1_i + add2_i});
        sent++;
      end
      hold_v = out_valid && !out_ready;
      hold_r = result_o;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_extra", 32'd1, 32'd0);
        end else begin
          chk("stream_data", 32'(result_o), 32'(q.pop_front()));
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 32'(got), 32'(n));
    repeat (2) @(negedge clk);
    chk("stream_tail", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    add1_i     = '0;
    add2_i     = '0;
    out_ready  = 1'b0;
    key_in     = 1'b0;
    key_shift  = 1'b0;
    key_commit = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    chk("rst_armed", 32'(key_armed), 32'd0);
    chk("rst_err", 32'(key_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    load_key(8'hA5, 8);
    chk("key_ok_armed", 32'(key_armed), 32'd1);
    chk("key_ok_err", 32'(key_err), 32'd0);

    run_one("add_1234", 16'h1234, 16'h1111, 17'h02345);
    run_one("add_00ff", 16'h00FF, 16'h0001, 17'h00000);
    run_one("add_ffff", 16'hFFFF, 16'h0001, 17'h0FF00);
    run_one("add_8000", 16'h8000, 16'h8000, 17'h10000);

    load_key(8'hA7, 8);
    chk("key_a7_armed", 32'(key_armed), 32'd1);
    run_one("km0_flip", 16'h1234, 16'h1111, 17'h0234A);

    load_key(8'hA4, 8);
    run_one("kc0_flip", 16'h1234, 16'h1111, 17'h02346);

    load_key(8'hA5, 5);
    chk("bad_err", 32'(key_err), 32'd1);
    chk("bad_armed", 32'(key_armed), 32'd0);
    chk("bad_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("bad_err_pulse", 32'(key_err), 32'd0);

    load_key(8'hA5, 8);
    chk("rearm", 32'(key_armed), 32'd1);
    stream(2, 4, 6);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      add1_i    = 16'h4321;
      add2_i    = 16'h1010;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_armed", 32'(key_armed), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd0);
    chk("mid_rst_res", 32'(result_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_replay", 32'(out_valid), 32'd0);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
